// File: rtl/soc_control_pkg.sv
// soc_control_pkg: register map, CONTROL bit positions and helpers shared by soc_control_mc
package soc_control_pkg;
  typedef enum logic [7:0] {
    SOCCTL_CONTROL   = 8'd0,
    SOCCTL_INT_EN    = 8'd1,
    SOCCTL_INT_PEND  = 8'd2,
    SOCCTL_INT_MODE  = 8'd3,
    SOCCTL_INT_CLAIM = 8'd4,
    SOCCTL_WDT       = 8'd5
  } socctl_mc_t;
  localparam int HALT = 0;
  localparam int CRES = 1;
  localparam int SRES = 2;
  localparam int GIE  = 3;
  localparam logic [31:0] CONTROL_WMASK = 32'hFFFF000F;
  function automatic logic [4:0] lowest_idx(input logic [31:0] a);
    lowest_idx = '0;
    for (int i = 31; i >= 0; i--)
      if (a[i]) lowest_idx = 5'(i);
  endfunction
endpackage

// File: rtl/soc_control_if.sv
// SoC_MemBus / SoC_InterruptBus: memory-bus slave port and interrupt request bundle
interface SoC_MemBus;
  logic        request;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport Master(output request, write, addr, wdata, input rdata, ready);
  modport Slave(input request, write, addr, wdata, output rdata, ready);
endinterface

interface SoC_InterruptBus;
  logic [31:0] interrupts;
  modport Generator(output interrupts);
  modport Handler(input interrupts);
endinterface

// File: rtl/soc_reset_pulse.sv
// soc_reset_pulse: self-timed reset pulse; a load (re)starts an 8-bit countdown, active while non-zero
module soc_reset_pulse #(
  parameter int RESET_PULSE = 16
) (
  input  logic clk,
  input  logic res_n,
  input  logic load,
  output logic active
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) cnt <= '0;
    else if (load) cnt <= 8'(RESET_PULSE);
    else if (cnt != '0) cnt <= cnt - 8'd1;
  assign active = cnt != '0;
endmodule

// File: rtl/soc_control_mc.sv
// soc_control_mc: multi-channel SoC controller (halt, resets, flags, edge/level interrupts, claim).
// Define SOC_CTL_WATCHDOG_EN to add the WDT register and its core-reset watchdog.
module soc_control_mc
  import soc_control_pkg::*;
#(
  parameter int BUS_LATENCY = 1,
  parameter int NUM_INTS    = 32,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_PULSE = 16
) (
  input  logic                clk,
  input  logic                res_n,
  output logic                core_halt,
  output logic                core_res,
  output logic                soc_res,
  output logic [15:0]         control_flags,
  input  logic [NUM_INTS-1:0] int_triggers,
  SoC_MemBus.Slave            mem_bus,
  SoC_InterruptBus.Generator  int_bus
);
  typedef enum logic [1:0] {ACC_MAIN, ACC_SET, ACC_CLEAR, ACC_TOGGLE} reg_access_t;
  function automatic logic [31:0] writeval(input reg_access_t acc, input logic [31:0] cur, input logic [31:0] wd);
    return acc == ACC_MAIN ? wd : acc == ACC_SET ? cur | wd : acc == ACC_CLEAR ? cur & ~wd : cur ^ wd;
  endfunction
  function automatic logic [31:0] clearonly(input reg_access_t acc, input logic [31:0] wd);
    return (acc == ACC_MAIN || acc == ACC_CLEAR) ? wd : '0;
  endfunction
  localparam int N = NUM_INTS;
  logic halt, gie, rst_hold, core_active, soc_active, wr, ctrl_wr, cres_load, sres_load, wdt_fire, unused_ok;
  logic [15:0] flags;
  logic [N-1:0] int_en, int_mode, mode_next, epend, prev, s, pend, a, pend_clr;
  logic [31:0] claim_q, ctrl_rd, ctrl_wv, wdt_rd, rdata_c;
  logic [7:0] reg_idx;
  reg_access_t acc;
  assign reg_idx = mem_bus.addr[11:4];
  assign acc = reg_access_t'(mem_bus.addr[3:2]);
  assign unused_ok = &{1'b0, mem_bus.addr[31:12], mem_bus.addr[1:0], ctrl_wv[15:4], ctrl_wv[2:1]};
  // the soft SoC reset locks out every bus write for its duration
  assign wr = mem_bus.request && mem_bus.write && !soc_active;
  assign ctrl_wr = wr && reg_idx == SOCCTL_CONTROL;
  assign ctrl_rd = {flags, 12'b0, gie, soc_active, core_active, halt};
  assign ctrl_wv = writeval(acc, ctrl_rd, mem_bus.wdata) & CONTROL_WMASK;
  assign cres_load = (ctrl_wr && acc != ACC_CLEAR && mem_bus.wdata[CRES]) || wdt_fire;
  assign sres_load = ctrl_wr && acc != ACC_CLEAR && mem_bus.wdata[SRES];
  assign mode_next = (wr && reg_idx == SOCCTL_INT_MODE) ? N'(writeval(acc, 32'(int_mode), mem_bus.wdata)) : int_mode;
  assign pend_clr = (wr && reg_idx == SOCCTL_INT_PEND) ? N'(clearonly(acc, mem_bus.wdata)) : '0;
  assign pend = (int_mode & epend) | (~int_mode & s);
  assign a = pend & int_en & {N{gie}};
  assign rdata_c = acc != ACC_MAIN ? '0 :
                   reg_idx == SOCCTL_CONTROL   ? ctrl_rd :
                   reg_idx == SOCCTL_INT_EN    ? 32'(int_en) :
                   reg_idx == SOCCTL_INT_PEND  ? 32'(pend) :
                   reg_idx == SOCCTL_INT_MODE  ? 32'(int_mode) :
                   reg_idx == SOCCTL_INT_CLAIM ? claim_q :
                   reg_idx == SOCCTL_WDT       ? wdt_rd : '0;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = int_triggers;
  end else begin : g_sync
    logic [N-1:0] q [SYNC_STAGES];
    always_ff @(posedge clk or negedge res_n)
      if (!res_n) begin
        for (int i = 0; i < SYNC_STAGES; i++) q[i] <= '0;
      end else begin
        q[0] <= int_triggers;
        for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
      end
    assign s = q[SYNC_STAGES-1];
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      rst_hold <= 1'b1;
      halt     <= 1'b0;
      gie      <= 1'b1;
      flags    <= '0;
      int_en   <= '0;
      int_mode <= '0;
      epend    <= '0;
      prev     <= '0;
      claim_q  <= '0;
    end else begin
      rst_hold <= 1'b0;
      prev     <= s;
      claim_q  <= {|a, 26'b0, lowest_idx(32'(a))};
      int_mode <= mode_next;
      // a new edge outranks a same-cycle clear so no request is dropped
      epend    <= soc_active ? '0 : (epend & ~pend_clr & ~(mode_next ^ int_mode)) | (s & ~prev & mode_next);
      if (soc_active) int_en <= '0;
      else if (wr && reg_idx == SOCCTL_INT_EN) int_en <= N'(writeval(acc, 32'(int_en), mem_bus.wdata));
      if (soc_active) halt <= 1'b0;
      else if (ctrl_wr) halt <= ctrl_wv[HALT];
      if (ctrl_wr) begin
        gie   <= ctrl_wv[GIE];
        flags <= ctrl_wv[31:16];
      end
    end
  soc_reset_pulse #(.RESET_PULSE(RESET_PULSE)) u_core (.clk(clk), .res_n(res_n), .load(cres_load), .active(core_active));
  soc_reset_pulse #(.RESET_PULSE(RESET_PULSE)) u_soc (.clk(clk), .res_n(res_n), .load(sres_load), .active(soc_active));
`ifdef SOC_CTL_WATCHDOG_EN
  logic wdt_en, wdt_wr;
  logic [23:0] wdt_reload, wdt_cnt;
  logic [31:0] wdt_wv;
  assign wdt_wr = wr && reg_idx == SOCCTL_WDT;
  assign wdt_wv = writeval(acc, wdt_rd, mem_bus.wdata);
  assign wdt_rd = {wdt_en, 7'b0, wdt_reload};
  assign wdt_fire = wdt_en && !halt && wdt_cnt == '0 && !wdt_wr;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      wdt_en     <= 1'b0;
      wdt_reload <= '0;
      wdt_cnt    <= '0;
    end else if (wdt_wr) begin
      wdt_en     <= wdt_wv[31];
      wdt_reload <= wdt_wv[23:0];
      wdt_cnt    <= wdt_wv[23:0];
    end else if (wdt_en && !halt) begin
      wdt_cnt <= wdt_cnt == '0 ? wdt_reload : wdt_cnt - 24'd1;
    end
`else
  assign wdt_rd = '0;
  assign wdt_fire = 1'b0;
`endif
  logic [BUS_LATENCY-1:0] rdy_q;
  logic [31:0] rd_q [BUS_LATENCY];
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      rdy_q <= '0;
      for (int i = 0; i < BUS_LATENCY; i++) rd_q[i] <= '0;
    end else begin
      rdy_q[0] <= mem_bus.request;
      rd_q[0]  <= rdata_c;
      for (int i = 1; i < BUS_LATENCY; i++) begin
        rdy_q[i] <= rdy_q[i-1];
        rd_q[i]  <= rd_q[i-1];
      end
    end
  assign mem_bus.ready = rdy_q[BUS_LATENCY-1];
  assign mem_bus.rdata = rd_q[BUS_LATENCY-1];
  assign int_bus.interrupts = 32'(a);
  assign core_halt = halt;
  assign core_res = rst_hold | core_active;
  assign soc_res = rst_hold | soc_active;
  assign control_flags = flags;
endmodule
